// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_IF   = 2'd3
  } mc_state_e;

  localparam logic [2:0] MEM_SIZE_B  = 3'b000;
  localparam logic [2:0] MEM_SIZE_H  = 3'b001;
  localparam logic [2:0] MEM_SIZE_W  = 3'b010;
  localparam logic [2:0] MEM_SIZE_BU = 3'b100;
  localparam logic [2:0] MEM_SIZE_HU = 3'b101;

  localparam logic [1:0] IO_HI_BITS_DEF = 2'b11;

  // Bytes moved for a funct3 size code; unknown codes behave as a word.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      MEM_SIZE_B, MEM_SIZE_BU: size_bytes = 3'd1;
      MEM_SIZE_H, MEM_SIZE_HU: size_bytes = 3'd2;
      default:                 size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-data extension: sign/zero extends byte and half loads, passes words through.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    case (size)
      MEM_SIZE_B:  ext = {{24{raw[7]}}, raw[7:0]};
      MEM_SIZE_H:  ext = {{16{raw[15]}}, raw[15:0]};
      MEM_SIZE_BU: ext = {24'b0, raw[7:0]};
      MEM_SIZE_HU: ext = {16'b0, raw[15:0]};
      default:     ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller for the LSB data port and instruction fetch.
// Optional IO_STALL_EN: stores to the IO region wait while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_HI_BITS = IO_HI_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        data_valid,
  input  logic        data_way,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ready,
  output logic [31:0] data_rdata,
  input  logic        inst_valid,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic        inst_ready,
  output logic [31:0] inst_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_e   state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic        data_ready_q, data_ready_d;
  logic        inst_ready_q, inst_ready_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [31:0] inst_data_q, inst_data_d;

  logic [2:0]  n_bytes;
  logic [1:0]  byte_sel;
  logic [31:0] asm_next;
  logic [31:0] ext_word;
  logic        io_stall;
  logic        wr_en;

  assign n_bytes = size_bytes(size_q);

`ifdef IO_STALL_EN
  assign io_stall = (addr_q[17:16] == IO_HI_BITS) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ (^IO_HI_BITS);
  assign io_stall  = 1'b0;
`endif

  // mem_din in a given cycle carries the byte addressed one cycle earlier (k-1).
  always_comb begin
    byte_sel = 2'(k_q - 3'd1);
    asm_next = asm_q;
    if ((state_q == MC_RD || state_q == MC_IF) && k_q != 3'd0)
      asm_next[{byte_sel, 3'b000} +: 8] = mem_din;
  end

  mem_load_ext u_load_ext (
    .size (size_q),
    .raw  (asm_next),
    .ext  (ext_word)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    data_ready_d = data_ready_q;
    inst_ready_d = inst_ready_q;
    data_rdata_d = data_rdata_q;
    inst_data_d  = inst_data_q;
    mem_a        = 32'd0;
    mem_dout     = 8'd0;
    wr_en        = 1'b0;

    case (state_q)
      MC_RD, MC_IF: if (k_q < n_bytes) mem_a = addr_q + 32'(k_q);
      MC_WR: begin
        mem_a    = addr_q + 32'(k_q);
        mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
        wr_en    = !io_stall;
      end
      default: ;
    endcase

    if (rdy) begin
      data_ready_d = 1'b0;
      inst_ready_d = 1'b0;
      case (state_q)
        MC_IDLE: begin
          // The requester still holds valid during our own ready pulse.
          if (!data_ready_q && !inst_ready_q) begin
            if (data_valid) begin
              state_d = data_way ? MC_WR : MC_RD;
              addr_d  = data_addr;
              wdata_d = data_wdata;
              size_d  = data_size;
              k_d     = 3'd0;
              asm_d   = 32'd0;
            end else if (inst_valid && !inst_flush) begin
              state_d = MC_IF;
              addr_d  = inst_addr;
              size_d  = MEM_SIZE_W;
              k_d     = 3'd0;
              asm_d   = 32'd0;
            end
          end
        end
        MC_RD, MC_IF: begin
          asm_d = asm_next;
          if (state_q == MC_IF && inst_flush) begin
            state_d = MC_IDLE;
          end else if (k_q == n_bytes) begin
            state_d = MC_IDLE;
            if (state_q == MC_IF) begin
              inst_ready_d = 1'b1;
              inst_data_d  = ext_word;
            end else begin
              data_ready_d = 1'b1;
              data_rdata_d = ext_word;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
        MC_WR: begin
          if (wr_en) begin
            if (k_q == n_bytes - 3'd1) begin
              state_d      = MC_IDLE;
              data_ready_d = 1'b1;
              data_rdata_d = 32'd0;
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        default: state_d = MC_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MC_IDLE;
      k_q          <= 3'd0;
      size_q       <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      asm_q        <= 32'd0;
      data_ready_q <= 1'b0;
      inst_ready_q <= 1'b0;
      data_rdata_q <= 32'd0;
      inst_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      data_ready_q <= data_ready_d;
      inst_ready_q <= inst_ready_d;
      data_rdata_q <= data_rdata_d;
      inst_data_q  <= inst_data_d;
    end
  end

  assign mem_wr     = wr_en & rdy;
  assign data_ready = data_ready_q & rdy;
  assign inst_ready = inst_ready_q & rdy & ~inst_flush;
  assign data_rdata = data_rdata_q;
  assign inst_data  = inst_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed timing cases plus randomized traffic on both ports.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        data_valid = 1'b0;
  logic        data_way = 1'b0;
  logic [2:0]  data_size = 3'd0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic        inst_flush = 1'b0;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .data_valid     (data_valid),
    .data_way       (data_way),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_ready     (data_ready),
    .data_rdata     (data_rdata),
    .inst_valid     (inst_valid),
    .inst_addr      (inst_addr),
    .inst_flush     (inst_flush),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] data_exp_q[$];
  logic [31:0] inst_exp_q[$];
  wr_t         wr_exp_q[$];
  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic        random_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [2:0] size);
    if (size == 3'b000 || size == 3'b100) return 1;
    if (size == 3'b001 || size == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr, input int n);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < n; i++) w = w | (32'(ref_rd(addr + 32'(i))) << (8 * i));
    return w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // RAM with one-cycle read latency; it shares the global enable with the controller.
  always @(posedge clk) if (rdy) mem_din <= ram_rd(mem_a);

  always @(negedge clk) begin
    if (!rst) begin
      if (data_ready) begin
        if (data_exp_q.size() == 0) check("data_ready_unexpected", {31'b0, data_ready}, 32'd0);
        else check("data_rdata", data_rdata, data_exp_q.pop_front());
      end
      if (inst_ready) begin
        if (inst_exp_q.size() == 0) check("inst_ready_unexpected", {31'b0, inst_ready}, 32'd0);
        else check("inst_data", inst_data, inst_exp_q.pop_front());
      end
      if (mem_wr) begin
        wr_t w;
        ram[mem_a] = mem_dout;
        if (wr_exp_q.size() == 0) check("mem_wr_unexpected", {31'b0, mem_wr}, 32'd0);
        else begin
          w = wr_exp_q.pop_front();
          check("mem_wr_addr", mem_a, w.a);
          check("mem_wr_byte", {24'b0, mem_dout}, {24'b0, w.d});
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (random_on) begin
      rdy            = ($urandom_range(0, 7) != 0);
      io_buffer_full = ($urandom_range(0, 3) == 0);
    end
  end

  // Called and returns at posedge+1; exp_lat < 0 skips the latency check.
  task automatic do_data(input logic way, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_lat, input string name);
    int n = nbytes(size);
    int cyc = 0;
    bit got = 0;
    logic [31:0] w;
    if (way) begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] a = addr + 32'(i);
        logic [7:0]  b = 8'(wdata >> (8 * i));
        ref_mem[a] = b;
        wr_exp_q.push_back('{a: a, d: b});
      end
      data_exp_q.push_back(32'd0);
    end else begin
      w = ref_word(addr, n);
      case (size)
        3'b000:  data_exp_q.push_back(w >= 32'd128   ? w - 32'd256   : w);
        3'b001:  data_exp_q.push_back(w >= 32'd32768 ? w - 32'd65536 : w);
        default: data_exp_q.push_back(w);
      endcase
    end
    data_valid = 1'b1;
    data_way   = way;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wdata;
    while (cyc < 400) begin
      @(negedge clk);
      if (data_ready) begin got = 1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_done"}, {31'b0, got}, 32'd1);
    if (exp_lat >= 0) check({name, "_lat"}, 32'(cyc), 32'(exp_lat));
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int exp_lat, input int flush_at, input string name);
    int cyc = 0;
    bit got = 0;
    bit flushed = 0;
    inst_exp_q.push_back(ref_word(addr, 4));
    inst_valid = 1'b1;
    inst_addr  = addr;
    while (cyc < 400) begin
      if (cyc == flush_at) inst_flush = 1'b1;
      @(negedge clk);
      if (inst_flush) begin
        if (rdy) begin flushed = 1; break; end
      end else if (inst_ready) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (flushed) void'(inst_exp_q.pop_back());
    check({name, "_done"}, {31'b0, got | flushed}, 32'd1);
    if (exp_lat >= 0) check({name, "_lat"}, 32'(cyc), 32'(exp_lat));
    @(posedge clk); #1;
    inst_valid = 1'b0;
    inst_flush = 1'b0;
  endtask

  initial begin
    int io_lat;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data_ready", {31'b0, data_ready}, 32'd0);
    check("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    @(posedge clk); #1;

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h200, 8'h80); preload(32'h201, 8'hFF);
    do_data(1'b0, 3'b010, 32'h100, 32'd0, 6, "lw");
    do_data(1'b0, 3'b000, 32'h200, 32'd0, 3, "lb");
    do_data(1'b0, 3'b100, 32'h200, 32'd0, 3, "lbu");
    do_data(1'b0, 3'b001, 32'h200, 32'd0, 4, "lh");
    do_data(1'b0, 3'b101, 32'h200, 32'd0, 4, "lhu");
    do_data(1'b0, 3'b011, 32'h100, 32'd0, 6, "l_undef");
    do_data(1'b1, 3'b001, 32'h300, 32'hAABBCCDD, 3, "sh");
    check("sh_0x302_untouched", {24'b0, ram_rd(32'h302)}, {24'b0, init_byte(32'h302)});
    do_data(1'b0, 3'b010, 32'h300, 32'd0, 6, "lw_after_sh");

    fork
      do_data(1'b0, 3'b010, 32'h100, 32'd0, 6, "arb_data");
      do_fetch(32'h1000, 13, -1, "arb_inst");
    join

    do_fetch(32'h1004, -1, 3, "flush");
    @(negedge clk);
    check("flush_idle_mem_a", mem_a, 32'd0);
    check("flush_no_ready", {31'b0, inst_ready}, 32'd0);
    @(posedge clk); #1;
    do_fetch(32'h10, 6, -1, "fetch_after_flush");

`ifdef IO_STALL_EN
    io_lat = 7;
`else
    io_lat = 2;
`endif
    fork
      do_data(1'b1, 3'b000, 32'h30000, 32'h000000EE, io_lat, "io_sb");
      begin
        @(posedge clk); #1 io_buffer_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 io_buffer_full = 1'b0;
      end
    join

    random_on = 1'b1;
    fork
      for (int i = 0; i < 250; i++) begin
        logic [31:0] a;
        int sel = $urandom_range(0, 9);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (sel == 0)      a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        else if (sel == 1) a = 32'h30000 + 32'($urandom_range(0, 3));
        else               a = 32'($urandom_range(0, 63));
        do_data(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, -1, "rnd_data");
      end
      for (int j = 0; j < 120; j++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_fetch(32'h1000 + 32'($urandom_range(0, 255)), -1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1, "rnd_fetch");
      end
    join
    random_on = 1'b0;
    @(posedge clk); #2;
    rdy = 1'b1;
    io_buffer_full = 1'b0;
    repeat (10) @(posedge clk);
    check("data_queue_drained", 32'(data_exp_q.size()), 32'd0);
    check("inst_queue_drained", 32'(inst_exp_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
